// File: rtl/tdp18k_fifo_rd_fwft_if.sv
// Stream and FIFO-read-port bundle for the FWFT read stage.
// Signal suffixes are from the point of view of the FWFT stage (slave modport).
interface tdp18k_fifo_rd_fwft_if #(
   parameter int DATA_WIDTH = 18,
   parameter int SKID_DEPTH = 2
);
   localparam int LW = $clog2(SKID_DEPTH + 1);

   logic                  FLUSH_i;
   logic                  EMPTY_i;
   logic                  REN_o;
   logic [DATA_WIDTH-1:0] RDATA_i;
   logic                  M_VALID_o;
   logic                  M_READY_i;
   logic [DATA_WIDTH-1:0] M_DATA_o;
   logic [LW-1:0]         LEVEL_o;

   // The FWFT stage itself
   modport slave (
      input  FLUSH_i, EMPTY_i, RDATA_i, M_READY_i,
      output REN_o, M_VALID_o, M_DATA_o, LEVEL_o
   );

   // The surrounding FIFO / stream consumer
   modport master (
      output FLUSH_i, EMPTY_i, RDATA_i, M_READY_i,
      input  REN_o, M_VALID_o, M_DATA_o, LEVEL_o
   );
endinterface

// File: rtl/tdp18k_fifo_rd_fwft.sv
// First-word-fall-through adapter for the 18K BRAM FIFO read port.
// Reads are issued only while the skid buffer plus in-flight reads leave room,
// so returning data always has a slot and the stream sustains one word/clock.
// Optional macro TDP18K_FWFT_STATS_EN adds a saturating accepted-transfer counter.
module tdp18k_fifo_rd_fwft #(
   parameter int DATA_WIDTH = 18,
   parameter int RD_LATENCY = 1,
   parameter int SKID_DEPTH = 2
) (
   input  logic        CLK_i,
   input  logic        RST_i,
`ifdef TDP18K_FWFT_STATS_EN
   output logic [15:0] STAT_CNT_o,
`endif
   tdp18k_fifo_rd_fwft_if.slave bus
);

   localparam int PW = $clog2(SKID_DEPTH);
   localparam int OW = PW + 1;
   localparam int SW = OW + 1;
   localparam int LW = $clog2(SKID_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [PW-1:0]         wrPtr_q, wrPtr_d;
   logic [PW-1:0]         rdPtr_q, rdPtr_d;
   logic [OW-1:0]         occ_q, occ_d;
   logic [RD_LATENCY-1:0] inflight_q, inflight_d;
   logic [OW-1:0]         inflightCnt;
   logic [SW-1:0]         demand;
   logic                  valid;
   logic                  pop;
   logic                  push;
   logic                  ren;

   // Issue decision: count committed slots (buffered + in flight - leaving now)
   always_comb begin
      inflightCnt = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflightCnt = inflightCnt + OW'(inflight_q[i]);
      end
      valid  = (occ_q != '0);
      pop    = valid & bus.M_READY_i;
      push   = inflight_q[RD_LATENCY-1];
      demand = SW'(occ_q) + SW'(inflightCnt) - SW'(pop);
      ren    = !RST_i && !bus.FLUSH_i && !bus.EMPTY_i && (demand < SW'(SKID_DEPTH));
   end

   // Next-state for pointers, occupancy and in-flight tags; flush wipes everything
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      occ_d      = occ_q;
      inflight_d = inflight_q;
      if (bus.FLUSH_i) begin
         wrPtr_d    = '0;
         rdPtr_d    = '0;
         occ_d      = '0;
         inflight_d = '0;
      end else begin
         wrPtr_d    = wrPtr_q + PW'(push);
         rdPtr_d    = rdPtr_q + PW'(pop);
         occ_d      = occ_q + OW'(push) - OW'(pop);
         inflight_d = (inflight_q << 1) | RD_LATENCY'(ren);
      end
   end

   // Control state registers
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         occ_q      <= '0;
         inflight_q <= '0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
      end
   end

   // Skid storage; data returning from reads issued before a flush is dropped
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push && !bus.FLUSH_i) begin
         mem_q[wrPtr_q] <= bus.RDATA_i;
      end
   end

`ifdef TDP18K_FWFT_STATS_EN
   logic [15:0] statCnt_q;

   // Saturating count of accepted words; only reset clears it, not flush
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         statCnt_q <= '0;
      end else if (pop && (statCnt_q != 16'hFFFF)) begin
         statCnt_q <= statCnt_q + 16'd1;
      end
   end

   assign STAT_CNT_o = statCnt_q;
`endif

   assign bus.REN_o     = ren;
   assign bus.M_VALID_o = valid;
   assign bus.M_DATA_o  = mem_q[rdPtr_q];
   assign bus.LEVEL_o   = LW'(occ_q + inflightCnt);

endmodule

// File: tb/tb_tdp18k_fifo_rd_fwft.sv
// Bench for the FWFT read stage: a simple FIFO model feeds the DUT, expected
// words are queued when loaded, and a monitor pops/compares on every accepted word.
module tb_tdp18k_fifo_rd_fwft;

   logic        clk;
   logic        rst;
   logic        forceEmpty;
   logic [17:0] fifoMem [0:255];
   logic [7:0]  wrPtr;
   logic [7:0]  rdPtr;
   logic [17:0] expQ [$];
   logic [17:0] expWord;
   int          checks;
   int          errors;
`ifdef TDP18K_FWFT_STATS_EN
   logic [15:0] statCnt;
`endif

   tdp18k_fifo_rd_fwft_if #(.DATA_WIDTH(18), .SKID_DEPTH(2)) bus ();

   tdp18k_fifo_rd_fwft #(
      .DATA_WIDTH(18),
      .RD_LATENCY(1),
      .SKID_DEPTH(2)
   ) dut (
      .CLK_i(clk),
      .RST_i(rst),
`ifdef TDP18K_FWFT_STATS_EN
      .STAT_CNT_o(statCnt),
`endif
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO read-side model: one cycle read latency, flush/reset discard contents
   assign bus.EMPTY_i = forceEmpty || (wrPtr == rdPtr);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr       <= wrPtr;
         bus.RDATA_i <= '0;
      end else if (bus.FLUSH_i) begin
         rdPtr <= wrPtr;
      end else if (bus.REN_o) begin
         bus.RDATA_i <= fifoMem[rdPtr];
         rdPtr       <= rdPtr + 8'd1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic loadWord(input logic [17:0] word, input bit expectIt);
      fifoMem[wrPtr] = word;
      wrPtr = wrPtr + 8'd1;
      if (expectIt) expQ.push_back(word);
   endtask

   task automatic applyStimulus(input int n, input logic [17:0] base, input int nExpect);
      for (int i = 0; i < n; i++) begin
         loadWord(base + 18'(i), (i < nExpect));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input string name, input int maxCycles);
      int c;
      c = 0;
      while (expQ.size() != 0 && c < maxCycles) begin
         @(negedge clk);
         c++;
      end
      checkOutput(name, expQ.size(), 0);
   endtask

   // Scoreboard monitor: every accepted word must match the queue head
   always @(negedge clk) begin
      if (!rst && bus.M_VALID_o && bus.M_READY_i) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word actual=%0h required=none", bus.M_DATA_o);
         end else begin
            expWord = expQ.pop_front();
            checkOutput("stream_data", 32'(bus.M_DATA_o), 32'(expWord));
         end
      end
   end

   // Watchdog so a hung run still reports
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int renCnt, validCnt, firstRen, lastRen, firstValid;
      bit anyRen, anyValid, anyLevel;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      forceEmpty = 1'b0;
      wrPtr = '0;
      bus.FLUSH_i = 1'b0;
      bus.M_READY_i = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset_ren", bus.REN_o, 0);
      checkOutput("reset_valid", bus.M_VALID_o, 0);
      checkOutput("reset_data", bus.M_DATA_o, 0);
      checkOutput("reset_level", bus.LEVEL_o, 0);
      tick();
      rst = 1'b0;

      // Streaming: 8 words at full rate
      $display("[TB] streaming");
      bus.M_READY_i = 1'b1;
      applyStimulus(8, 18'h00001, 8);
      renCnt = 0; validCnt = 0; firstRen = -1; lastRen = -1; firstValid = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.REN_o) begin
            renCnt++;
            if (firstRen < 0) firstRen = c;
            lastRen = c;
         end
         if (bus.M_VALID_o) begin
            validCnt++;
            if (firstValid < 0) firstValid = c;
         end
      end
      checkOutput("stream_latency", firstValid - firstRen, 2);
      checkOutput("stream_ren_count", renCnt, 8);
      checkOutput("stream_ren_span", lastRen - firstRen, 7);
      checkOutput("stream_valid_count", validCnt, 8);
      checkOutput("stream_drained", expQ.size(), 0);

      // Back-pressure: only two reads outstanding while stalled
      $display("[TB] back-pressure");
      tick();
      bus.M_READY_i = 1'b0;
      applyStimulus(10, 18'h00001, 10);
      renCnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.REN_o) renCnt++;
      end
      checkOutput("bp_ren_count", renCnt, 2);
      checkOutput("bp_level", bus.LEVEL_o, 2);
      checkOutput("bp_valid", bus.M_VALID_o, 1);
      checkOutput("bp_hold_data", bus.M_DATA_o, 18'h00001);
      tick();
      bus.M_READY_i = 1'b1;
      validCnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.M_VALID_o) validCnt++;
      end
      checkOutput("bp_no_gap", validCnt, 10);
      @(negedge clk);
      checkOutput("bp_done_valid", bus.M_VALID_o, 0);
      checkOutput("bp_drained", expQ.size(), 0);

      // Empty gating
      $display("[TB] empty gating");
      tick();
      forceEmpty = 1'b1;
      applyStimulus(3, 18'h00201, 1);
      anyRen = 0; anyValid = 0; anyLevel = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         anyRen   |= bus.REN_o;
         anyValid |= bus.M_VALID_o;
         anyLevel |= (bus.LEVEL_o != 0);
      end
      checkOutput("empty_no_ren", anyRen, 0);
      checkOutput("empty_no_valid", anyValid, 0);
      checkOutput("empty_level", anyLevel, 0);
      tick();
      forceEmpty = 1'b0;
      renCnt = 0; validCnt = 0;
      @(negedge clk);
      if (bus.REN_o) renCnt++;
      if (bus.M_VALID_o) validCnt++;
      tick();
      forceEmpty = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.REN_o) renCnt++;
         if (bus.M_VALID_o) validCnt++;
      end
      checkOutput("empty_one_ren", renCnt, 1);
      checkOutput("empty_one_word", validCnt, 1);
      checkOutput("empty_drained", expQ.size(), 0);
      tick();
      bus.FLUSH_i = 1'b1;
      tick();
      bus.FLUSH_i = 1'b0;
      forceEmpty = 1'b0;

      // Flush with one word buffered and one read in flight
      $display("[TB] flush mid-flight");
      tick();
      bus.M_READY_i = 1'b0;
      loadWord(18'h00301, 1'b0);
      loadWord(18'h3FFFF, 1'b0);
      tick();
      tick();
      bus.FLUSH_i = 1'b1;
      @(negedge clk);
      checkOutput("flush_ren_low", bus.REN_o, 0);
      checkOutput("flush_level_before", bus.LEVEL_o, 2);
      tick();
      bus.FLUSH_i = 1'b0;
      bus.M_READY_i = 1'b1;
      @(negedge clk);
      checkOutput("flush_valid_after", bus.M_VALID_o, 0);
      checkOutput("flush_level_after", bus.LEVEL_o, 0);
      anyValid = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         anyValid |= bus.M_VALID_o;
      end
      checkOutput("flush_no_late_word", anyValid, 0);

      // Asynchronous reset while a word is presented
      $display("[TB] reset mid-transfer");
      tick();
      bus.M_READY_i = 1'b0;
      applyStimulus(2, 18'h00401, 0);
      repeat (3) @(negedge clk);
      checkOutput("rst_pre_valid", bus.M_VALID_o, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_valid", bus.M_VALID_o, 0);
      checkOutput("rst_async_ren", bus.REN_o, 0);
      checkOutput("rst_async_level", bus.LEVEL_o, 0);
      tick();
      rst = 1'b0;
      tick();
      bus.M_READY_i = 1'b1;
      applyStimulus(4, 18'h00501, 4);
      waitDrain("rst_resume_drain", 30);

`ifdef TDP18K_FWFT_STATS_EN
      // Saturating statistics counter
      $display("[TB] stats");
      tick();
      bus.M_READY_i = 1'b0;
      applyStimulus(3, 18'h00601, 3);
      tick();
      force dut.statCnt_q = 16'hFFFE;
      tick();
      release dut.statCnt_q;
      bus.M_READY_i = 1'b1;
      waitDrain("stats_drain", 20);
      repeat (3) @(negedge clk);
      checkOutput("stats_saturate", statCnt, 16'hFFFF);
      tick();
      bus.FLUSH_i = 1'b1;
      tick();
      bus.FLUSH_i = 1'b0;
      @(negedge clk);
      checkOutput("stats_flush_keep", statCnt, 16'hFFFF);
      rst = 1'b1;
      #1;
      checkOutput("stats_reset", statCnt, 0);
      tick();
      rst = 1'b0;
`endif

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
